snake_body: RTL and testbench

Circular position buffer holding every occupied cell of the snake, plus a self-collision checker. It sits between the movement stage, which supplies a new head coordinate each game tick, and the pixel generator, which consumes the released tail coordinate to clear that pixel. It replaces a bare FIFO with length tracking, growth, auto-fill at start, and a sequential head-versus-body scan.

---
 rtl/snake_pkg.sv | 25 ++
 rtl/snake_ram.sv | 31 +++
 rtl/snake_body.sv | 131 +++++++++++++
 tb/tb_snake_body.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Shared types for the snake body tracker: cell coordinates, FSM states,
// and the default buffer sizing.
package snake_pkg;

   localparam int POS_W            = 8;
   localparam int DEFAULT_MAX_LEN  = 32;
   localparam int DEFAULT_INIT_LEN = 3;

   typedef struct packed {
      logic [POS_W/2-1:0] x;
      logic [POS_W/2-1:0] y;
   } pos_t;

   typedef enum logic [1:0] {
      IDLE,
      WRITE,
      SCAN,
      DONE
   } body_state_t;

   function automatic logic same_cell(input pos_t a, input pos_t b);
      return (a.x == b.x) && (a.y == b.y);
   endfunction

endpackage

// File: rtl/snake_ram.sv
// Segment storage: one synchronous write port for the new head and two
// asynchronous read ports, one for the tail release and one for the scan.
module snake_ram
   import snake_pkg::*;
#(
   parameter int DEPTH = DEFAULT_MAX_LEN,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  pos_t          wr_data,
   input  logic [AW-1:0] tail_addr,
   output pos_t          tail_data,
   input  logic [AW-1:0] scan_addr,
   output pos_t          scan_data
);

   pos_t mem [DEPTH];

   // Contents need no reset: only cells between the pointers are ever read.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign tail_data = mem[tail_addr];
   assign scan_data = mem[scan_addr];

endmodule

// File: rtl/snake_body.sv
// Snake body tracker: circular buffer of occupied cells with length control,
// tail release and a one-entry-per-cycle head-versus-body collision scan.
module snake_body
   import snake_pkg::*;
#(
   parameter int MAX_LEN  = DEFAULT_MAX_LEN,
   parameter int INIT_LEN = DEFAULT_INIT_LEN
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     step,
   input  pos_t                     headPos,
   input  logic                     grow,
   output logic                     busy,
   output logic                     tailValid,
   output pos_t                     tailPos,
   output logic                     collision,
   output logic                     done,
   output logic [$clog2(MAX_LEN):0] length
);

   localparam int AW = $clog2(MAX_LEN);
   localparam int LW = AW + 1;

   body_state_t     state;
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [AW-1:0]   scan_idx;
   logic [LW-1:0]   scan_left;
   pos_t            head;
   logic            grow_req;

   pos_t            tail_data;
   pos_t            scan_data;
   logic            wr_en;
   logic            grow_eff;
   logic            extend;
   logic [LW-1:0]   new_len;
   logic [AW-1:0]   new_rd;

   snake_ram #(
      .DEPTH (MAX_LEN)
   ) u_ram (
      .clk       (clk),
      .wr_en     (wr_en),
      .wr_addr   (wr_ptr),
      .wr_data   (head),
      .tail_addr (rd_ptr),
      .tail_data (tail_data),
      .scan_addr (scan_idx),
      .scan_data (scan_data)
   );

   // Until INIT_LEN segments exist every step grows; at full a grow becomes a move.
   always_comb begin
      wr_en    = (state == WRITE);
      grow_eff = grow_req || (length < LW'(INIT_LEN));
      extend   = grow_eff && (length < LW'(MAX_LEN));
      new_len  = extend ? length + 1'b1 : length;
      new_rd   = extend ? rd_ptr : rd_ptr + 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         scan_idx  <= '0;
         scan_left <= '0;
         head      <= '0;
         grow_req  <= 1'b0;
         length    <= '0;
         busy      <= 1'b0;
         tailValid <= 1'b0;
         tailPos   <= '0;
         collision <= 1'b0;
         done      <= 1'b0;
      end else begin
         tailValid <= 1'b0;
         done      <= 1'b0;
         case (state)
            IDLE, DONE: begin
               if (step) begin
                  head     <= headPos;
                  grow_req <= grow;
                  busy     <= 1'b1;
                  state    <= WRITE;
               end else begin
                  state <= IDLE;
               end
            end
            WRITE: begin
               wr_ptr    <= wr_ptr + 1'b1;
               rd_ptr    <= new_rd;
               length    <= new_len;
               scan_idx  <= new_rd;
               scan_left <= new_len - 1'b1;
               if (!extend) begin
                  tailPos   <= tail_data;
                  tailValid <= 1'b1;
               end
               if (new_len >= LW'(2)) begin
                  state <= SCAN;
               end else begin
                  state <= DONE;
                  done  <= 1'b1;
                  busy  <= 1'b0;
               end
            end
            SCAN: begin
               // The freshly written head sits just past the last scanned entry.
               if (same_cell(scan_data, head)) begin
                  collision <= 1'b1;
               end
               if (scan_left == LW'(1)) begin
                  state <= DONE;
                  done  <= 1'b1;
                  busy  <= 1'b0;
               end else begin
                  scan_left <= scan_left - 1'b1;
                  scan_idx  <= scan_idx + 1'b1;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_snake_body.sv
// Self-checking bench for snake_body: directed vector table, multi-cycle
// corner sequences and randomized steps against a queue-based body model.
module tb_snake_body;

   localparam int MAX_LEN  = 32;
   localparam int INIT_LEN = 3;

   logic       clk;
   logic       reset;
   logic       step;
   logic [7:0] headPos;
   logic       grow;
   logic       busy;
   logic       tailValid;
   logic [7:0] tailPos;
   logic       collision;
   logic       done;
   logic [5:0] length;

   int checks;
   int errors;

   int         obs_done;
   int         obs_lat;
   int         obs_busy_done;
   int         obs_busy_first;
   int         obs_tv_cnt;
   int         obs_tv_idx;
   logic [7:0] obs_tail;

   logic [7:0] body[$];
   logic       m_coll;

   typedef struct {
      logic [7:0] head;
      logic       grow;
      logic       tv;
      logic [7:0] tail;
      int         len;
      logic       coll;
   } vec_t;

   vec_t vecs[12];

   snake_body #(
      .MAX_LEN  (MAX_LEN),
      .INIT_LEN (INIT_LEN)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .step      (step),
      .headPos   (headPos),
      .grow      (grow),
      .busy      (busy),
      .tailValid (tailValid),
      .tailPos   (tailPos),
      .collision (collision),
      .done      (done),
      .length    (length)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkValue(input string ctx, input string what, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s.%s: got %0h, expected %0h", ctx, what, actual, expected);
      end
   endtask

   // Reference: the body is an ordered list of cells, oldest first.
   task automatic modelStep(input logic [7:0] h, input logic g, output logic tv, output logic [7:0] tail);
      int n;
      logic grow_now;
      n        = body.size();
      grow_now = g || (n < INIT_LEN);
      tv       = 1'b0;
      tail     = 8'h00;
      if (!(grow_now && n < MAX_LEN)) begin
         tail = body.pop_front();
         tv   = 1'b1;
      end
      foreach (body[i]) begin
         if (body[i] == h) m_coll = 1'b1;
      end
      body.push_back(h);
   endtask

   // Called at a falling edge; leaves off at the falling edge where done is seen.
   task automatic applyStimulus(input logic [7:0] h, input logic g, input bit inject);
      int idx;
      obs_done       = 0;
      obs_lat        = -1;
      obs_busy_done  = -1;
      obs_busy_first = 0;
      obs_tv_cnt     = 0;
      obs_tv_idx     = -1;
      obs_tail       = 8'h00;
      step    = 1'b1;
      headPos = h;
      grow    = g;
      @(negedge clk);
      step = 1'b0;
      grow = 1'b0;
      obs_busy_first = int'(busy);
      idx = 0;
      while (idx < 80) begin
         if (inject && idx == 2) begin
            step = 1'b0;
            grow = 1'b0;
         end
         if (tailValid) begin
            obs_tv_cnt++;
            obs_tv_idx = idx;
            obs_tail   = tailPos;
         end
         if (done) begin
            obs_done      = 1;
            obs_lat       = idx;
            obs_busy_done = int'(busy);
            break;
         end
         if (inject && idx == 1) begin
            step    = 1'b1;
            headPos = ~h;
            grow    = 1'b1;
         end
         @(negedge clk);
         idx++;
      end
      step = 1'b0;
   endtask

   task automatic checkOutput(input string ctx, input logic tv, input logic [7:0] tail,
                              input int len, input logic coll);
      checkValue(ctx, "done_seen", obs_done, 1);
      checkValue(ctx, "busy_after_accept", obs_busy_first, 1);
      if (obs_done == 1) begin
         checkValue(ctx, "latency", obs_lat, (len >= 2) ? len : 1);
         checkValue(ctx, "busy_at_done", obs_busy_done, 0);
      end
      checkValue(ctx, "tail_pulses", obs_tv_cnt, int'(tv));
      if (tv) begin
         checkValue(ctx, "tail_pos", int'(obs_tail), int'(tail));
         checkValue(ctx, "tail_cycle", obs_tv_idx, 1);
      end
      checkValue(ctx, "length", int'(length), len);
      checkValue(ctx, "collision", int'(collision), int'(coll));
   endtask

   task automatic checkReset(input string ctx);
      checkValue(ctx, "length", int'(length), 0);
      checkValue(ctx, "busy", int'(busy), 0);
      checkValue(ctx, "tailValid", int'(tailValid), 0);
      checkValue(ctx, "tailPos", int'(tailPos), 0);
      checkValue(ctx, "collision", int'(collision), 0);
      checkValue(ctx, "done", int'(done), 0);
   endtask

   task automatic doReset(input string ctx);
      reset = 1'b1;
      step  = 1'b0;
      grow  = 1'b0;
      @(negedge clk);
      checkReset(ctx);
      @(negedge clk);
      reset = 1'b0;
      body.delete();
      m_coll = 1'b0;
   endtask

   task automatic modelledStep(input string ctx, input logic [7:0] h, input logic g, input bit inject);
      logic       tv;
      logic [7:0] tail;
      applyStimulus(h, g, inject);
      modelStep(h, g, tv, tail);
      checkOutput(ctx, tv, tail, body.size(), m_coll);
   endtask

   initial begin
      logic       tv_unused;
      logic [7:0] tail_unused;
      logic [7:0] rh;
      checks  = 0;
      errors  = 0;
      reset   = 1'b1;
      step    = 1'b0;
      grow    = 1'b0;
      headPos = 8'h00;
      m_coll  = 1'b0;

      vecs[0]  = '{8'h11, 1'b0, 1'b0, 8'h00, 1, 1'b0};
      vecs[1]  = '{8'h12, 1'b0, 1'b0, 8'h00, 2, 1'b0};
      vecs[2]  = '{8'h13, 1'b0, 1'b0, 8'h00, 3, 1'b0};
      vecs[3]  = '{8'h14, 1'b0, 1'b1, 8'h11, 3, 1'b0};
      vecs[4]  = '{8'h15, 1'b1, 1'b0, 8'h00, 4, 1'b0};
      vecs[5]  = '{8'h16, 1'b0, 1'b1, 8'h12, 4, 1'b0};
      vecs[6]  = '{8'h13, 1'b0, 1'b1, 8'h13, 4, 1'b0};
      vecs[7]  = '{8'h22, 1'b1, 1'b0, 8'h00, 5, 1'b0};
      vecs[8]  = '{8'h23, 1'b0, 1'b1, 8'h14, 5, 1'b0};
      vecs[9]  = '{8'h33, 1'b0, 1'b1, 8'h15, 5, 1'b0};
      vecs[10] = '{8'h32, 1'b0, 1'b1, 8'h16, 5, 1'b0};
      vecs[11] = '{8'h22, 1'b0, 1'b1, 8'h13, 5, 1'b1};

      doReset("reset0");

      for (int i = 0; i < 12; i++) begin
         applyStimulus(vecs[i].head, vecs[i].grow, 1'b0);
         modelStep(vecs[i].head, vecs[i].grow, tv_unused, tail_unused);
         checkOutput($sformatf("vec%0d", i), vecs[i].tv, vecs[i].tail, vecs[i].len, vecs[i].coll);
      end

      for (int i = 0; i < 27; i++) begin
         modelledStep($sformatf("fill%0d", i), 8'($urandom), 1'b1, 1'b0);
      end
      modelledStep("full_grow_inject", 8'h77, 1'b1, 1'b1);
      modelledStep("full_move", 8'h78, 1'b0, 1'b0);

      step    = 1'b1;
      headPos = 8'hAA;
      @(negedge clk);
      step = 1'b0;
      repeat (6) @(negedge clk);
      checkValue("midscan", "busy_before", int'(busy), 1);
      #2 reset = 1'b1;
      #1 checkReset("midscan");
      @(negedge clk);
      reset = 1'b0;
      body.delete();
      m_coll = 1'b0;

      modelledStep("first_after_reset", 8'h5A, 1'b0, 1'b0);

      for (int r = 0; r < 120; r++) begin
         if (r % 40 == 39) doReset($sformatf("rand_reset%0d", r));
         rh = {2'b00, 2'($urandom), 2'b00, 2'($urandom)};
         modelledStep($sformatf("rand%0d", r), rh, ($urandom_range(0, 3) == 0), 1'b0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
